bcd_stopwatch_core: RTL and testbench
=====================================

BCD_STOPWATCH_CORE -- requirements
Module: bcd_stopwatch_core

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (legal 2..8).
REQ-002 SHALL have parameter PRESCALE, default 120000, CLK cycles per count tick (legal >= 2).
REQ-003 SHALL have parameter WRAP, default 1: 1 = up-count wraps at all-9s; 0 = saturates and stops.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports start, stop, clear, lap, load  input  1 each  level-sampled commands, acted on every cycle asserted.
REQ-007 SHALL have port mode  input  1  0 = count up, 1 = count down; sampled only when a start is accepted.
REQ-008 SHALL have port load_value  input  4*DIGITS  BCD preset.
REQ-009 SHALL have port count  output  4*DIGITS  live BCD count, registered.
REQ-010 SHALL have port display  output  4*DIGITS  lap value when lap_hold=1, else count.
REQ-011 SHALL have ports running, lap_hold  output  1 each  status flags, registered.
REQ-012 SHALL have ports tick, done, overflow  output  1 each  one-cycle registered pulses.

Function
REQ-013 SHALL implement states STOPPED, RUNNING, EXPIRED; running=1 only in RUNNING.
REQ-014 SHALL apply command priority RST > clear > load > stop > start; a simultaneous start and stop SHALL leave/put the block in STOPPED.
REQ-015 SHALL on clear: count=0, lap_hold=0, go STOPPED from any state.
REQ-016 SHALL on load when not RUNNING: count=load_value with each digit >9 clamped to 9, go STOPPED; load in RUNNING is ignored.
REQ-017 SHALL on start in STOPPED: latch mode, zero prescaler, enter RUNNING; start in down mode with count=0 is ignored; start in RUNNING or EXPIRED is ignored.
REQ-018 SHALL on stop in RUNNING: enter STOPPED, count frozen, prescaler value discarded.
REQ-019 SHALL run the prescaler 0..PRESCALE-1 only in RUNNING; the count step occurs exactly PRESCALE cycles after start acceptance, then every PRESCALE cycles.
REQ-020 SHALL assert tick for one cycle, coincident with the first cycle count shows the stepped value.
REQ-021 SHALL step up in BCD with per-digit carry (x9 -> next digit +1, digit -> 0); mode is ignored while RUNNING.
REQ-022 SHALL on up step from all-9s: WRAP=1 -> count=0, overflow pulse, stay RUNNING; WRAP=0 -> count holds all-9s, overflow pulse, enter STOPPED.
REQ-023 SHALL step down in BCD with per-digit borrow (x0 -> digit 9, next digit -1).
REQ-024 SHALL on down step reaching 0: done pulse coincident with count=0 and tick, enter EXPIRED, running=0 that cycle.
REQ-025 SHALL on lap in RUNNING with lap_hold=0: capture count into lap register, lap_hold=1; count keeps stepping.
REQ-026 SHALL on lap with lap_hold=1 (any state): lap_hold=0; lap with lap_hold=0 outside RUNNING has no effect.
REQ-027 SHALL make lap level-sensitive per cycle; callers supply single-cycle pulses (debounce/edge-detect is external).
REQ-028 SHALL capture into the lap register the count value in the cycle lap is sampled (pre-step if a step coincides).

Reset
REQ-029 SHALL on RST: state STOPPED, count=0, lap register=0, display=0, prescaler=0, running=0, lap_hold=0, tick=0, done=0, overflow=0, latched mode=0.
REQ-030 SHALL let RST override every other input, including mid-RUNNING and with lap_hold=1; outputs reach reset values in the cycle after the RST edge.

Verification (DIGITS=2, PRESCALE=4 unless stated)
REQ-031 SHALL cover: RST, start mode=0 -> count 01 four cycles later with tick; run to 99 -> next step 00 with overflow pulse (WRAP=1); WRAP=0 -> holds 99, overflow, running=0.
REQ-032 SHALL cover: load 0x03, mode=1, start -> 02, 01, 00 at 4-cycle spacing; done pulse with 00; state EXPIRED; later start ignored; clear -> STOPPED.
REQ-033 SHALL cover: up-run, lap at count 05 -> display 05 while count reaches 08; second lap -> display equals count.
REQ-034 SHALL cover: start+stop same cycle in STOPPED -> running stays 0; stop at count 03 mid-prescale, restart -> next step exactly 4 cycles after restart.
REQ-035 SHALL cover: load 0xA7 when STOPPED -> count 97; load 0x12 while RUNNING -> ignored; down start with count 00 -> ignored.
REQ-036 SHALL cover: RST asserted mid-RUNNING with lap_hold=1 -> all outputs at reset values next cycle, no tick/done/overflow pulse.

Source files
------------

// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core
//
// BCD stopwatch / countdown timer core. A prescaler divides CLK down to a count
// tick; on each tick the BCD count steps up or down depending on the mode
// latched when the run was started. A lap register can freeze the displayed
// value while the live count keeps running.
//
// Parameters
//   DIGITS     number of BCD digits (2..8)
//   PRESCALE   CLK cycles per count step (>= 2)
//   WRAP       1: up-count wraps from all-9s to 0; 0: saturates and stops
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   start      begin counting (mode sampled here), ignored unless STOPPED
//   stop       halt counting, prescaler phase discarded
//   clear      zero count, drop lap hold, go STOPPED
//   lap        capture count into lap register / release lap hold
//   load       preset count from load_value (not while RUNNING)
//   mode       0 = count up, 1 = count down
//   load_value BCD preset, digits above 9 clamp to 9
//   count      live BCD count
//   display    lap value while lap_hold, else count
//   running    high while RUNNING
//   lap_hold   high while display shows the lap register
//   tick       one-cycle pulse with the first cycle of each stepped count
//   done       one-cycle pulse when a down-count reaches zero
//   overflow   one-cycle pulse on an up-step from all-9s
module bcd_stopwatch_core #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 120000,
    parameter bit          WRAP     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    input  logic                  load,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   display,
    output logic                  running,
    output logic                  lap_hold,
    output logic                  tick,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StStopped = 2'd0,
        StRunning = 2'd1,
        StExpired = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Add one with per-digit decimal carry; all-9s rolls over to all-0s.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Subtract one with per-digit decimal borrow.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Force any non-decimal nibble (A..F) to 9 so the count stays legal BCD.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    state_e          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    lap_q, lap_d;
    logic            lap_hold_q, lap_hold_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            mode_q, mode_d;
    logic            running_q, running_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;

    logic [W-1:0]    count_inc;
    logic [W-1:0]    count_dec;
    logic [W-1:0]    load_clamped;
    logic            count_zero;
    logic            count_nines;
    logic            is_running;

    assign count_inc    = bcd_inc(count_q);
    assign count_dec    = bcd_dec(count_q);
    assign load_clamped = bcd_clamp(load_value);
    assign count_zero   = (count_q == '0);
    assign count_nines  = bcd_all_nines(count_q);
    assign is_running   = (state_q == StRunning);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        lap_d      = lap_q;
        lap_hold_d = lap_hold_q;
        presc_d    = presc_q;
        mode_d     = mode_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        overflow_d = 1'b0;

        // Lap toggles independently of the command chain; it sees the
        // pre-step count, so a coincident step does not leak into the capture.
        if (lap) begin
            if (lap_hold_q) begin
                lap_hold_d = 1'b0;
            end else if (is_running) begin
                lap_d      = count_q;
                lap_hold_d = 1'b1;
            end
        end

        // Commands in priority order; an ignored command falls through so
        // lower-priority commands and the running step still apply.
        if (clear) begin
            count_d    = '0;
            lap_hold_d = 1'b0;
            presc_d    = '0;
            state_d    = StStopped;
        end else if (load && !is_running) begin
            count_d = load_clamped;
            presc_d = '0;
            state_d = StStopped;
        end else if (stop && is_running) begin
            presc_d = '0;
            state_d = StStopped;
        end else if (start && !stop && (state_q == StStopped) && !(mode && count_zero)) begin
            mode_d  = mode;
            presc_d = '0;
            state_d = StRunning;
        end else if (is_running) begin
            if (presc_q == PresLast) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (!mode_q) begin
                    if (count_nines) begin
                        overflow_d = 1'b1;
                        if (WRAP) begin
                            count_d = '0;
                        end else begin
                            state_d = StStopped;
                        end
                    end else begin
                        count_d = count_inc;
                    end
                end else begin
                    count_d = count_dec;
                    if (count_dec == '0) begin
                        done_d  = 1'b1;
                        state_d = StExpired;
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        running_d = (state_d == StRunning);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StStopped;
            count_q    <= '0;
            lap_q      <= '0;
            lap_hold_q <= 1'b0;
            presc_q    <= '0;
            mode_q     <= 1'b0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            lap_q      <= lap_d;
            lap_hold_q <= lap_hold_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            running_q  <= running_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign display  = lap_hold_q ? lap_q : count_q;
    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign tick     = tick_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Testbench for bcd_stopwatch_core (DIGITS=2, PRESCALE=4), one wrapping and
// one saturating instance driven by the same stimulus. An integer-valued
// model tracks both every cycle; a vector table and short hand-written
// sequences pin down the corner cases with fixed expectations.
module tb_bcd_stopwatch_core;

    localparam int unsigned DIGITS   = 2;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned W        = 4 * DIGITS;
    localparam int unsigned OW       = 2 * W + 5;
    localparam int          MAXV     = 10 ** DIGITS - 1;

    localparam int S_STOP = 0;
    localparam int S_RUN  = 1;
    localparam int S_EXP  = 2;

    // command bits {start, stop, clear, lap, load, mode}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_START = 6'b100000;
    localparam logic [5:0] C_STOP  = 6'b010000;
    localparam logic [5:0] C_CLEAR = 6'b001000;
    localparam logic [5:0] C_LAP   = 6'b000100;
    localparam logic [5:0] C_LOAD  = 6'b000010;
    localparam logic [5:0] C_MODE  = 6'b000001;

    logic         CLK;
    logic         RST;
    logic         start, stop, clear, lap, load, mode;
    logic [W-1:0] load_value;

    logic [W-1:0] count_w, display_w, count_s, display_s;
    logic         running_w, lap_hold_w, tick_w, done_w, overflow_w;
    logic         running_s, lap_hold_s, tick_s, done_s, overflow_s;

    logic [OW-1:0] out_w, out_s;
    assign out_w = {count_w, display_w, running_w, lap_hold_w, tick_w, done_w, overflow_w};
    assign out_s = {count_s, display_s, running_s, lap_hold_s, tick_s, done_s, overflow_s};

    bcd_stopwatch_core #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .WRAP(1'b1)) dut_w (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .load(load), .mode(mode), .load_value(load_value), .count(count_w),
        .display(display_w), .running(running_w), .lap_hold(lap_hold_w), .tick(tick_w),
        .done(done_w), .overflow(overflow_w)
    );

    bcd_stopwatch_core #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .WRAP(1'b0)) dut_s (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .load(load), .mode(mode), .load_value(load_value), .count(count_s),
        .display(display_s), .running(running_s), .lap_hold(lap_hold_s), .tick(tick_s),
        .done(done_s), .overflow(overflow_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model (integer count) ----------------
    int m_state[2];
    int m_val[2];
    int m_lap[2];
    int m_pre[2];
    bit m_hold[2];
    bit m_mode[2];
    bit m_tick[2];
    bit m_done[2];
    bit m_ovf[2];

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        t = v;
        r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [W-1:0] b);
        int v;
        int d;
        v = 0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    task automatic model_step(input int k, input bit wrap);
        m_tick[k] = 1'b0;
        m_done[k] = 1'b0;
        m_ovf[k]  = 1'b0;
        if (RST) begin
            m_state[k] = S_STOP;
            m_val[k]   = 0;
            m_lap[k]   = 0;
            m_pre[k]   = 0;
            m_hold[k]  = 1'b0;
            m_mode[k]  = 1'b0;
        end else begin
            if (lap) begin
                if (m_hold[k]) begin
                    m_hold[k] = 1'b0;
                end else if (m_state[k] == S_RUN) begin
                    m_lap[k]  = m_val[k];
                    m_hold[k] = 1'b1;
                end
            end
            if (clear) begin
                m_val[k]   = 0;
                m_hold[k]  = 1'b0;
                m_pre[k]   = 0;
                m_state[k] = S_STOP;
            end else if (load && m_state[k] != S_RUN) begin
                m_val[k]   = from_bcd_clamped(load_value);
                m_state[k] = S_STOP;
            end else if (stop && m_state[k] == S_RUN) begin
                m_state[k] = S_STOP;
                m_pre[k]   = 0;
            end else if (start && !stop && m_state[k] == S_STOP && !(mode && m_val[k] == 0)) begin
                m_state[k] = S_RUN;
                m_mode[k]  = mode;
                m_pre[k]   = 0;
            end else if (m_state[k] == S_RUN) begin
                m_pre[k]++;
                if (m_pre[k] == int'(PRESCALE)) begin
                    m_pre[k]  = 0;
                    m_tick[k] = 1'b1;
                    if (!m_mode[k]) begin
                        if (m_val[k] == MAXV) begin
                            m_ovf[k] = 1'b1;
                            if (wrap) m_val[k] = 0;
                            else m_state[k] = S_STOP;
                        end else begin
                            m_val[k]++;
                        end
                    end else begin
                        m_val[k]--;
                        if (m_val[k] == 0) begin
                            m_done[k]  = 1'b1;
                            m_state[k] = S_EXP;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [OW-1:0] model_out(input int k);
        logic [W-1:0] c;
        c = to_bcd(m_val[k]);
        return {c, (m_hold[k] ? to_bcd(m_lap[k]) : c), (m_state[k] == S_RUN), m_hold[k],
                m_tick[k], m_done[k], m_ovf[k]};
    endfunction

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge CLK);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
        chk("model_wrap", 32'(out_w), 32'(model_out(0)));
        chk("model_sat", 32'(out_s), 32'(model_out(1)));
    endtask

    task automatic set_cmd(input logic [5:0] cmd, input logic [W-1:0] lv);
        {start, stop, clear, lap, load, mode} = cmd;
        load_value = lv;
    endtask

    // ---------------- directed vector table (wrapping instance) ----------------
    typedef struct {
        logic [5:0]    cmd;
        logic [W-1:0]  lv;
        int            cyc;
        logic [OW-1:0] exp;   // {count, display, running, lap_hold, tick, done, overflow}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] cmd, input logic [W-1:0] lv, input int cyc,
                                input logic [W-1:0] ec, input logic [W-1:0] ed,
                                input logic [4:0] ef);
        vec_t v;
        v.cmd = cmd;
        v.lv  = lv;
        v.cyc = cyc;
        v.exp = {ec, ed, ef};
        return v;
    endfunction

    initial begin
        RST = 1'b1;
        set_cmd(C_NONE, '0);

        // reset
        cycle();
        cycle();
        chk("reset_wrap", 32'(out_w), 32'd0);
        chk("reset_sat", 32'(out_s), 32'd0);
        RST = 1'b0;

        //                  cmd                lv     cyc  count  disp   run/hold/tick/done/ovf
        tbl.push_back(mk(C_START,           8'h00, 1,  8'h00, 8'h00, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 3,  8'h00, 8'h00, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 1,  8'h01, 8'h01, 5'b10100));
        tbl.push_back(mk(C_NONE,            8'h00, 1,  8'h01, 8'h01, 5'b10000));
        tbl.push_back(mk(C_START | C_STOP,  8'h00, 1,  8'h01, 8'h01, 5'b00000));
        tbl.push_back(mk(C_START | C_STOP,  8'h00, 1,  8'h01, 8'h01, 5'b00000));
        tbl.push_back(mk(C_LOAD,            8'hA7, 1,  8'h97, 8'h97, 5'b00000));
        tbl.push_back(mk(C_START,           8'h00, 1,  8'h97, 8'h97, 5'b10000));
        tbl.push_back(mk(C_LOAD,            8'h12, 1,  8'h97, 8'h97, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 2,  8'h97, 8'h97, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 1,  8'h98, 8'h98, 5'b10100));
        tbl.push_back(mk(C_NONE,            8'h00, 4,  8'h99, 8'h99, 5'b10100));
        tbl.push_back(mk(C_NONE,            8'h00, 4,  8'h00, 8'h00, 5'b10101));
        tbl.push_back(mk(C_STOP,            8'h00, 1,  8'h00, 8'h00, 5'b00000));
        tbl.push_back(mk(C_START | C_MODE,  8'h00, 1,  8'h00, 8'h00, 5'b00000));
        tbl.push_back(mk(C_LOAD,            8'h03, 1,  8'h03, 8'h03, 5'b00000));
        tbl.push_back(mk(C_START | C_MODE,  8'h00, 1,  8'h03, 8'h03, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 4,  8'h02, 8'h02, 5'b10100));
        tbl.push_back(mk(C_NONE,            8'h00, 4,  8'h01, 8'h01, 5'b10100));
        tbl.push_back(mk(C_NONE,            8'h00, 4,  8'h00, 8'h00, 5'b00110));
        tbl.push_back(mk(C_START,           8'h00, 1,  8'h00, 8'h00, 5'b00000));
        tbl.push_back(mk(C_NONE,            8'h00, 5,  8'h00, 8'h00, 5'b00000));
        tbl.push_back(mk(C_CLEAR,           8'h00, 1,  8'h00, 8'h00, 5'b00000));
        tbl.push_back(mk(C_START,           8'h00, 1,  8'h00, 8'h00, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 20, 8'h05, 8'h05, 5'b10100));
        tbl.push_back(mk(C_LAP,             8'h00, 1,  8'h05, 8'h05, 5'b11000));
        tbl.push_back(mk(C_NONE,            8'h00, 11, 8'h08, 8'h05, 5'b11100));
        tbl.push_back(mk(C_LAP,             8'h00, 1,  8'h08, 8'h08, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 1,  8'h08, 8'h08, 5'b10000));
        tbl.push_back(mk(C_STOP,            8'h00, 1,  8'h08, 8'h08, 5'b00000));
        tbl.push_back(mk(C_START,           8'h00, 1,  8'h08, 8'h08, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 3,  8'h08, 8'h08, 5'b10000));
        tbl.push_back(mk(C_NONE,            8'h00, 1,  8'h09, 8'h09, 5'b10100));
        tbl.push_back(mk(C_LAP,             8'h00, 1,  8'h09, 8'h09, 5'b11000));
        tbl.push_back(mk(C_STOP,            8'h00, 1,  8'h09, 8'h09, 5'b01000));
        tbl.push_back(mk(C_LAP,             8'h00, 1,  8'h09, 8'h09, 5'b00000));
        tbl.push_back(mk(C_LAP,             8'h00, 1,  8'h09, 8'h09, 5'b00000));
        tbl.push_back(mk(C_CLEAR,           8'h00, 1,  8'h00, 8'h00, 5'b00000));

        foreach (tbl[i]) begin
            set_cmd(tbl[i].cmd, tbl[i].lv);
            for (int c = 0; c < tbl[i].cyc; c++) cycle();
            chk($sformatf("vec[%0d]", i), 32'(out_w), 32'(tbl[i].exp));
        end
        set_cmd(C_NONE, '0);

        // saturating vs wrapping up-count from 98
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        set_cmd(C_LOAD, 8'h98);
        cycle();
        set_cmd(C_START, 8'h00);
        cycle();
        set_cmd(C_NONE, 8'h00);
        repeat (4) cycle();
        chk("sat_99_count", 32'(count_s), 32'h99);
        chk("sat_99_tick", 32'(tick_s), 32'd1);
        repeat (4) cycle();
        chk("sat_hold_count", 32'(count_s), 32'h99);
        chk("sat_overflow", 32'(overflow_s), 32'd1);
        chk("sat_running", 32'(running_s), 32'd0);
        chk("wrap_count", 32'(count_w), 32'h00);
        chk("wrap_overflow", 32'(overflow_w), 32'd1);
        chk("wrap_running", 32'(running_w), 32'd1);

        // reset mid-run with lap held, on the cycle a step is due
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        set_cmd(C_START, 8'h00);
        cycle();
        set_cmd(C_LAP, 8'h00);
        cycle();
        chk("pre_rst_hold", 32'(lap_hold_w), 32'd1);
        set_cmd(C_NONE, 8'h00);
        cycle();
        cycle();
        RST = 1'b1;
        cycle();
        chk("rst_mid_run_wrap", 32'(out_w), 32'd0);
        chk("rst_mid_run_sat", 32'(out_s), 32'd0);
        RST = 1'b0;
        cycle();
        chk("after_rst_idle", 32'(out_w), 32'd0);

        // randomized stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            RST        = ($urandom_range(0, 999) < 5);
            start      = ($urandom_range(0, 99) < 12);
            stop       = ($urandom_range(0, 99) < 4);
            clear      = ($urandom_range(0, 99) < 2);
            lap        = ($urandom_range(0, 99) < 5);
            load       = ($urandom_range(0, 99) < 4);
            mode       = 1'($urandom_range(0, 1));
            load_value = W'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
